// File: rtl/shift_reg_n.sv
// ---------------------------------------------------------------------------
// shift_reg_n
//
// Parametrised universal shift register with a built-in serial-transmit
// sequencer. In IDLE the register holds, loads, shifts left/right or
// (optionally) rotates according to mode. A start pulse in IDLE launches a
// WIDTH-bit LSB-first transmit on sout, flagged by busy and followed by a
// one-cycle done pulse.
//
// Optional feature macro: SHREG_ROTATE_EN
//   defined   -> modes 3'b100 / 3'b101 rotate left / right
//   undefined -> those modes hold and no rotate mux is built
//
// Parameters:
//   WIDTH      register width in bits (>= 2)
//   RESET_VAL  value of q after reset
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high reset
//   mode   in   3      register operation, sampled only in IDLE
//   d      in   WIDTH  parallel load data
//   sin_l  in   1      serial input into bit 0 on shift-left
//   sin_r  in   1      serial input into bit WIDTH-1 on shift-right/transmit
//   start  in   1      request a serial transmit
//   q      out  WIDTH  register contents
//   sout   out  1      serial output, equal to q[0]
//   busy   out  1      transmit in progress
//   done   out  1      one-cycle pulse after a transmit
// ---------------------------------------------------------------------------
module shift_reg_n #(
    parameter int unsigned        WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    // Encoding chosen so busy and done are each a single state bit, which
    // keeps both outputs glitch-free straight off the state register.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            q       <= RESET_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q       <= q_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    // start has priority over mode; q holds this cycle
                    state_d = StShift;
                    cnt_d   = '0;
                end else begin
                    case (mode)
                        3'b001: q_d = d;
                        3'b010: q_d = {q[WIDTH-2:0], sin_l};
                        3'b011: q_d = {sin_r, q[WIDTH-1:1]};
`ifdef SHREG_ROTATE_EN
                        3'b100: q_d = {q[WIDTH-2:0], q[WIDTH-1]};
                        3'b101: q_d = {q[0], q[WIDTH-1:1]};
`endif
                        default: q_d = q;
                    endcase
                end
            end
            StShift: begin
                q_d = {sin_r, q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    // counter parks at WIDTH-1 rather than wrapping
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        sout = q[0];
        busy = state_q[0];
        done = state_q[1];
    end

endmodule

// File: tb/tb_shift_reg_n.sv
module tb_shift_reg_n;

    logic       clk;
    logic       reset;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic       start;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    shift_reg_n #(
        .WIDTH     (8),
        .RESET_VAL (8'h3C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .d     (d),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .start (start),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] eq, input logic eb,
                            input logic ed);
        exp_t e;
        e.tag  = tag;
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        cmp({e.tag, ".q"}, q, e.q);
        cmp({e.tag, ".sout"}, {7'b0, sout}, {7'b0, e.q[0]});
        cmp({e.tag, ".busy"}, {7'b0, busy}, {7'b0, e.busy});
        cmp({e.tag, ".done"}, {7'b0, done}, {7'b0, e.done});
    endtask

    // Expectation queued with the stimulus, checked 1 time unit after the edge.
    task automatic tick(input string tag, input logic [7:0] eq, input logic eb,
                        input logic ed);
        push_exp(tag, eq, eb, ed);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        logic [7:0] ones;
        logic [7:0] word;
        ones  = 8'hFF;
        reset = 1'b0;
        mode  = 3'b000;
        d     = 8'h00;
        sin_l = 1'b0;
        sin_r = 1'b0;
        start = 1'b0;

        // Asynchronous reset between edges (edges at 5, 15, ...)
        #12 reset = 1'b1;
        #1;
        push_exp("reset_async", 8'h3C, 1'b0, 1'b0);
        pop_check();
        @(negedge clk) reset = 1'b0;
        tick("after_reset_hold", 8'h3C, 1'b0, 1'b0);

        // Load and shifts
        mode = 3'b001; d = 8'h81;
        tick("load_81", 8'h81, 1'b0, 1'b0);
        mode = 3'b010; sin_l = 1'b1;
        tick("shl_sin1", 8'h03, 1'b0, 1'b0);
        mode = 3'b011; sin_r = 1'b0;
        tick("shr_sin0", 8'h01, 1'b0, 1'b0);
        mode = 3'b011; sin_r = 1'b1;
        tick("shr_sin1", 8'h80, 1'b0, 1'b0);
        mode = 3'b000;
        tick("hold_000", 8'h80, 1'b0, 1'b0);
        mode = 3'b110;
        tick("hold_110", 8'h80, 1'b0, 1'b0);
        mode = 3'b111;
        tick("hold_111", 8'h80, 1'b0, 1'b0);

        // Rotate (or hold without the feature)
        mode = 3'b001; d = 8'h81;
        tick("load_81b", 8'h81, 1'b0, 1'b0);
        mode = 3'b100;
`ifdef SHREG_ROTATE_EN
        tick("rotl", 8'h03, 1'b0, 1'b0);
        mode = 3'b101;
        tick("rotr", 8'h81, 1'b0, 1'b0);
        tick("rotr2", 8'hC0, 1'b0, 1'b0);
`else
        tick("rotl_hold", 8'h81, 1'b0, 1'b0);
        mode = 3'b101;
        tick("rotr_hold", 8'h81, 1'b0, 1'b0);
`endif

        // Transmit A5 with sin_r = 0
        mode = 3'b001; d = 8'hA5; sin_r = 1'b0;
        tick("load_A5", 8'hA5, 1'b0, 1'b0);
        mode = 3'b000; start = 1'b1;
        tick("tx_start", 8'hA5, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            word = 8'hA5 >> k;
            tick($sformatf("tx_bit%0d", k), word, 1'b1, 1'b0);
        end
        tick("tx_done", 8'h00, 1'b0, 1'b1);
        tick("tx_idle", 8'h00, 1'b0, 1'b0);

        // start wins over load; mode/start ignored in SHIFT and DONE
        mode = 3'b001; d = 8'h5A;
        tick("load_5A", 8'h5A, 1'b0, 1'b0);
        d = 8'hFF; start = 1'b1; sin_r = 1'b1;
        tick("start_over_load", 8'h5A, 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) begin
            start = k[0];
            d     = 8'h00;
            word  = (8'h5A >> k) | ~(ones >> k);
            tick($sformatf("ign_bit%0d", k), word, 1'b1, 1'b0);
        end
        start = 1'b1;
        tick("ign_done", 8'hFF, 1'b0, 1'b1);
        tick("ign_start_in_done", 8'hFF, 1'b0, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick("ign_idle", 8'hFF, 1'b0, 1'b0);

        // Reset during a transmit
        mode = 3'b001; d = 8'hC3; sin_r = 1'b0;
        tick("load_C3", 8'hC3, 1'b0, 1'b0);
        mode = 3'b000; start = 1'b1;
        tick("abort_start", 8'hC3, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k < 4; k++) begin
            word = 8'hC3 >> k;
            tick($sformatf("abort_bit%0d", k), word, 1'b1, 1'b0);
        end
        #2 reset = 1'b1;
        #1;
        push_exp("abort_reset", 8'h3C, 1'b0, 1'b0);
        pop_check();
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick($sformatf("abort_no_done%0d", k), 8'h3C, 1'b0, 1'b0);
        end

        // Full transmit after the abort, sin_r = 1
        sin_r = 1'b1; start = 1'b1;
        tick("re_start", 8'h3C, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            word = (8'h3C >> k) | ~(ones >> k);
            tick($sformatf("re_bit%0d", k), word, 1'b1, 1'b0);
        end
        tick("re_done", 8'hFF, 1'b0, 1'b1);
        tick("re_idle", 8'hFF, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
